// File: rtl/mem_ctrl_responder.sv
// rtl/mem_ctrl_responder.sv - unified dual-port RAM serving CPU instruction fetch and data load/store
// Optional build macro MEM_ADDR_CHECK_EN adds data-port range/alignment checking with mem_err.
module mem_ctrl_responder #(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_instr_addr,
  output logic [31:0] mem_instr_data,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_wr,
  input  logic        mem_rd,
  output logic [31:0] mem_rd_data,
  output logic        mem_valid,
  output logic        mem_err
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY     = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

  logic [31:0]           r_mem [0:DEPTH-1];
  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic                  r_is_wr;
  logic                  r_bad;
  logic [31:0]           r_instr_data;
  logic [31:0]           r_rd_data;

  logic [DEPTH_LOG2-1:0] w_instr_idx;
  logic [DEPTH_LOG2-1:0] w_data_idx;
  logic                  w_access;
  logic                  w_ram_we;
  logic                  w_bad;
  logic                  w_unused;

  assign w_instr_idx = mem_instr_addr[DEPTH_LOG2+1:2];
  assign w_data_idx  = mem_addr[DEPTH_LOG2+1:2];
  assign w_unused    = ^{mem_instr_addr[31:DEPTH_LOG2+2], mem_instr_addr[1:0],
                         mem_addr[31:DEPTH_LOG2+2], mem_addr[1:0]};

`ifdef MEM_ADDR_CHECK_EN
  assign w_bad   = ((mem_addr >> (DEPTH_LOG2 + 2)) != 32'd0) || (mem_addr[1:0] != 2'b00);
  assign mem_err = (r_state == DONE) && r_bad;
`else
  assign w_bad   = 1'b0;
  assign mem_err = 1'b0;
`endif

  // The RAM access happens on the edge that leaves the last BUSY cycle.
  assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);
  assign w_ram_we = w_access && r_is_wr && !r_bad;

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  // Non-blocking read of the old word gives read-before-write on a same-edge collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_data <= '0;
    end else begin
      r_instr_data <= r_mem[w_instr_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_is_wr   <= 1'b0;
      r_bad     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_wr || mem_rd) begin
            r_idx   <= w_data_idx;
            r_wdata <= mem_wr_data;
            r_is_wr <= mem_wr;
            r_bad   <= w_bad;
            r_cnt   <= CNT_INIT;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (!r_is_wr) begin
              r_rd_data <= r_bad ? BAD_DATA : r_mem[r_idx];
            end
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_instr_data = r_instr_data;
  assign mem_rd_data    = r_rd_data;
  assign mem_valid      = (r_state == DONE);

endmodule

// File: tb/tb_mem_ctrl_responder.sv
// tb/tb_mem_ctrl_responder.sv - randomized bench with transaction-level reference model for mem_ctrl_responder
// Honors MEM_ADDR_CHECK_EN for the expected error/address behaviour.
module tb_mem_ctrl_responder;

  localparam int DL    = 12;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << DL;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_instr_addr;
  logic [31:0] mem_instr_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr;
  logic        mem_rd;
  logic [31:0] mem_rd_data;
  logic        mem_valid;
  logic        mem_err;

  mem_ctrl_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_instr_addr (mem_instr_addr),
    .mem_instr_data (mem_instr_data),
    .mem_addr       (mem_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_wr         (mem_wr),
    .mem_rd         (mem_rd),
    .mem_rd_data    (mem_rd_data),
    .mem_valid      (mem_valid),
    .mem_err        (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a transaction accepted in cycle c completes (mem_valid) in cycle c+LAT+1,
  // its RAM effect lands on the edge entering that completion cycle.
  logic [31:0] mdl_mem [DEPTH];
  logic [31:0] e_instr = '0;
  logic [31:0] e_rd    = '0;
  logic        e_valid = 1'b0;
  logic        e_err   = 1'b0;
  bit          m_pend  = 1'b0;
  longint      m_due   = 0;
  longint      cyc     = 0;
  bit          m_wr;
  bit          m_bad;
  int          m_idx;
  logic [31:0] m_data;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & (DEPTH - 1));
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef MEM_ADDR_CHECK_EN
    return ((a >> (DL + 2)) != 0) || ((a & 32'h3) != 0);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_instr = '0;
      e_rd    = '0;
      e_valid = 1'b0;
      e_err   = 1'b0;
      m_pend  = 1'b0;
    end else begin
      logic [31:0] nxt_instr;
      nxt_instr = mdl_mem[widx(mem_instr_addr)];
      if (m_pend && cyc == m_due - 1) begin
        if (m_wr) begin
          if (!m_bad) mdl_mem[m_idx] = m_data;
        end else begin
          e_rd = m_bad ? 32'hDEAD_BEEF : mdl_mem[m_idx];
        end
      end
      if (m_pend && cyc == m_due) begin
        m_pend = 1'b0;
      end else if (!m_pend && (mem_wr || mem_rd)) begin
        m_pend = 1'b1;
        m_due  = cyc + LAT + 1;
        m_wr   = mem_wr;
        m_bad  = addr_bad(mem_addr);
        m_idx  = widx(mem_addr);
        m_data = mem_wr_data;
      end
      cyc++;
      e_valid = m_pend && (cyc == m_due);
      e_err   = e_valid && m_bad;
      e_instr = nxt_instr;
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("cyc_instr_data", mem_instr_data, e_instr);
      check("cyc_rd_data", mem_rd_data, e_rd);
      check("cyc_valid", {31'b0, mem_valid}, {31'b0, e_valid});
      check("cyc_err", {31'b0, mem_err}, {31'b0, e_err});
    end
  end

  task automatic preload(input int idx, input logic [31:0] v);
    mdl_mem[idx]   = v;
    dut.r_mem[idx] = v;
  endtask

  // Called at posedge+1 with the FSM idle; returns at the negedge of the completion cycle.
  task automatic do_txn(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rdv, output logic err);
    mem_wr = wr; mem_rd = rd; mem_addr = a; mem_wr_data = d;
    lat = 0;
    @(negedge clk);
    while (!mem_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!mem_valid) check("txn_timeout", {31'b0, mem_valid}, 32'd1);
    rdv = mem_rd_data;
    err = mem_err;
  endtask

  task automatic release_req();
    @(posedge clk); #1;
    mem_wr = 1'b0;
    mem_rd = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 7) == 0) a = $urandom;
    else a = (32'($urandom_range(0, 31)) << 2) | (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
    return a;
  endfunction

  int          lat;
  logic [31:0] rdv;
  logic        err;

  initial begin
    rst_n = 1'b0; mem_instr_addr = '0; mem_addr = '0; mem_wr_data = '0; mem_wr = 1'b0; mem_rd = 1'b0;
    for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
    #12;
    check("rst_instr_data", mem_instr_data, 32'd0);
    check("rst_rd_data", mem_rd_data, 32'd0);
    check("rst_valid", {31'b0, mem_valid}, 32'd0);
    check("rst_err", {31'b0, mem_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmp_en = 1'b1;

    preload(4, 32'h1234_5678);
    mem_instr_addr = 32'h10;
    @(posedge clk); @(negedge clk);
    check("fetch_word4", mem_instr_data, 32'h1234_5678);
    @(posedge clk); #1;

    do_txn(1'b1, 1'b0, 32'h40, 32'hCAFE_F00D, lat, rdv, err);
    check("store_latency", 32'(lat), 32'd3);
    check("store_err", {31'b0, err}, 32'd0);
    release_req();
    do_txn(1'b0, 1'b1, 32'h40, 32'h0, lat, rdv, err);
    check("load_latency", 32'(lat), 32'd3);
    check("load_data", rdv, 32'hCAFE_F00D);
    release_req();

    do_txn(1'b1, 1'b1, 32'h80, 32'hA5A5_A5A5, lat, rdv, err);
    check("rdwr_rd_unchanged", rdv, 32'hCAFE_F00D);
    release_req();
    do_txn(1'b0, 1'b1, 32'h80, 32'h0, lat, rdv, err);
    check("rdwr_readback", rdv, 32'hA5A5_A5A5);
    release_req();

    preload(8, 32'h1);
    mem_instr_addr = 32'h20;
    do_txn(1'b1, 1'b0, 32'h20, 32'h2, lat, rdv, err);
    check("collision_old", mem_instr_data, 32'h1);
    release_req();
    @(negedge clk);
    check("collision_new", mem_instr_data, 32'h2);
    @(posedge clk); #1;

    preload(12, 32'h5555_0000);
    mem_instr_addr = 32'h0;
    mem_wr = 1'b1; mem_addr = 32'h30; mem_wr_data = 32'h7777_7777;
    @(posedge clk); #2;
    rst_n = 1'b0;
    mem_wr = 1'b0;
    #1;
    check("abort_instr_zero", mem_instr_data, 32'd0);
    check("abort_rd_zero", mem_rd_data, 32'd0);
    check("abort_valid_zero", {31'b0, mem_valid}, 32'd0);
    check("abort_err_zero", {31'b0, mem_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      check("abort_no_valid", {31'b0, mem_valid}, 32'd0);
    end
    @(posedge clk); #1;
    mem_instr_addr = 32'h30;
    @(posedge clk); @(negedge clk);
    check("abort_ram_kept", mem_instr_data, 32'h5555_0000);
    @(posedge clk); #1;
    do_txn(1'b0, 1'b1, 32'h30, 32'h0, lat, rdv, err);
    check("abort_then_load", rdv, 32'h5555_0000);
    release_req();

    preload(0, 32'h0BAD_F00D);
    do_txn(1'b0, 1'b1, 32'h0010_0002, 32'h0, lat, rdv, err);
`ifdef MEM_ADDR_CHECK_EN
    check("oor_read_data", rdv, 32'hDEAD_BEEF);
    check("oor_read_err", {31'b0, err}, 32'd1);
`else
    check("wrap_read_data", rdv, 32'h0BAD_F00D);
    check("wrap_read_err", {31'b0, err}, 32'd0);
`endif
    release_req();

    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      mem_wr         = ($urandom_range(0, 3) == 0);
      mem_rd         = ($urandom_range(0, 2) == 0);
      mem_addr       = rand_addr();
      mem_wr_data    = $urandom;
      mem_instr_addr = rand_addr();
      if (n % 700 == 350) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(posedge clk); #1;
    mem_wr = 1'b0;
    mem_rd = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
